rvs_rt_collector: RTL

Scalar-side receiver for the RVV backend's XRF retire channel and VCSR.vxsat update channel. It accepts up to `NUM_RT_UOP` scalar-destination writebacks per cycle from RVV, buffers them in retire order, and drains them onto the scalar core's limited XRF write ports. It also accumulates the sticky vxsat bit. It sits in the RVS model/agent between the RVV retire stage and the scalar register file.

---
 rtl/rvs_rt_collector_pkg.sv | 24 ++
 rtl/rvs_rt_collector_fifo.sv | 89 ++++++++
 rtl/rvs_rt_collector.sv | 131 +++++++++++++
 3 files changed

// File: rtl/rvs_rt_collector_pkg.sv
// rvs_rt_collector_pkg
// Shared types and sizes for the scalar-side RVV retire collector.
//   NUM_RT_UOP       : retire lanes delivered by RVV per cycle
//   XLEN             : scalar data width
//   VCSR_VXSAT_WIDTH : width of a per-uop vxsat flag
//   RT2XRF_t         : one lane of the RVV -> XRF retire channel
//   rt_entry_t       : one buffered writeback {index, data}
package rvs_rt_collector_pkg;

  localparam int NUM_RT_UOP       = 4;
  localparam int XLEN             = 32;
  localparam int VCSR_VXSAT_WIDTH = 1;

  typedef struct packed {
    logic [4:0]      rt_index;
    logic [XLEN-1:0] rt_data;
  } RT2XRF_t;

  typedef struct packed {
    logic [4:0]      idx;
    logic [XLEN-1:0] data;
  } rt_entry_t;

endpackage

// File: rtl/rvs_rt_collector_fifo.sv
// rvs_multi_fifo
// Circular buffer accepting up to N_PUSH entries and releasing up to N_POP
// entries per cycle.
//   clk, rst_n  : clock, synchronous active-low reset
//   push_valid  : per-lane push request
//   push_data   : per-lane entry
//   push_ready  : per-lane ready, from registered occupancy only
//   pop_cnt     : number of head entries to release this cycle (<= count)
//   head_data   : the N_POP oldest entries, head first
//   count       : occupied entries
module rvs_multi_fifo
  import rvs_rt_collector_pkg::*;
#(
  parameter int N_PUSH = 4,
  parameter int N_POP  = 1,
  parameter int DEPTH  = 8,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic      [N_PUSH-1:0] push_valid,
  input  rt_entry_t [N_PUSH-1:0] push_data,
  output logic      [N_PUSH-1:0] push_ready,
  input  logic      [CW-1:0]     pop_cnt,
  output rt_entry_t [N_POP-1:0]  head_data,
  output logic      [CW-1:0]     count
);

  rt_entry_t       mem_q [DEPTH];
  rt_entry_t       mem_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   push_cnt;
  logic [PW-1:0]   slot;

  // Lane i may push only if i entries ahead of it still fit; space freed by
  // a same-cycle pop is deliberately not visible here.
  always_comb begin
    for (int i = 0; i < N_PUSH; i++) begin
      push_ready[i] = rst_n && ((DEPTH - int'(count_q)) > i);
    end
  end

  // Accepted lanes are compacted in lane order starting at the tail, so a
  // gap in the valid mask never leaves a hole in the buffer.
  always_comb begin
    mem_d    = mem_q;
    push_cnt = '0;
    slot     = wr_ptr_q;
    for (int i = 0; i < N_PUSH; i++) begin
      if (push_valid[i] && push_ready[i]) begin
        mem_d[slot] = push_data[i];
        slot        = slot + 1'b1;
        push_cnt    = push_cnt + 1'b1;
      end
    end
    wr_ptr_d = slot;
    rd_ptr_d = rd_ptr_q + PW'(pop_cnt);
    count_d  = count_q + push_cnt - pop_cnt;
  end

  always_comb begin
    for (int j = 0; j < N_POP; j++) begin
      head_data[j] = mem_q[rd_ptr_q + PW'(j)];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: only entries covered by count are ever read.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign count = count_q;

endmodule

// File: rtl/rvs_rt_collector.sv
// rvs_rt_collector
// Receives RVV scalar-destination writebacks, buffers them in retire order
// and drains them onto the scalar XRF write ports; also keeps sticky vxsat.
//   clk, rst_n            : clock, synchronous active-low reset
//   rt_xrf_rvv2rvs        : per-lane {rt_index, rt_data}
//   rt_xrf_valid_rvv2rvs  : per-lane valid
//   rt_xrf_ready_rvs2rvv  : per-lane ready
//   wr_vxsat_valid/_vxsat : per-uop saturation update
//   wr_vxsat_ready        : vxsat channel ready
//   vxsat_clr             : CSR clear of sticky vxsat
//   xrf_grant             : scalar pipe frees its write ports this cycle
//   xrf_wen/waddr/wdata   : registered XRF write ports
//   vxsat_q               : sticky vxsat
//   pending_cnt, rt_empty : buffer occupancy
module rvs_rt_collector
  import rvs_rt_collector_pkg::*;
#(
  parameter int XRF_WR_PORTS = 1,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                                              clk,
  input  logic                                              rst_n,
  input  RT2XRF_t [NUM_RT_UOP-1:0]                          rt_xrf_rvv2rvs,
  input  logic    [NUM_RT_UOP-1:0]                          rt_xrf_valid_rvv2rvs,
  output logic    [NUM_RT_UOP-1:0]                          rt_xrf_ready_rvs2rvv,
  input  logic    [NUM_RT_UOP-1:0]                          wr_vxsat_valid,
  input  logic    [NUM_RT_UOP-1:0][VCSR_VXSAT_WIDTH-1:0]    wr_vxsat,
  output logic                                              wr_vxsat_ready,
  input  logic                                              vxsat_clr,
  input  logic                                              xrf_grant,
  output logic    [XRF_WR_PORTS-1:0]                        xrf_wen,
  output logic    [XRF_WR_PORTS-1:0][4:0]                   xrf_waddr,
  output logic    [XRF_WR_PORTS-1:0][XLEN-1:0]              xrf_wdata,
  output logic                                              vxsat_q,
  output logic    [$clog2(FIFO_DEPTH+1)-1:0]                pending_cnt,
  output logic                                              rt_empty
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  rt_entry_t [NUM_RT_UOP-1:0]           push_data;
  rt_entry_t [XRF_WR_PORTS-1:0]         head_data;
  logic      [CW-1:0]                   count;
  logic      [CW-1:0]                   pop_cnt;
  logic      [XRF_WR_PORTS-1:0]         xrf_wen_d, xrf_wen_q;
  logic      [XRF_WR_PORTS-1:0][4:0]    xrf_waddr_d, xrf_waddr_q;
  logic      [XRF_WR_PORTS-1:0][XLEN-1:0] xrf_wdata_d, xrf_wdata_q;
  logic                                 vxsat_set, vxsat_d;

  always_comb begin
    for (int i = 0; i < NUM_RT_UOP; i++) begin
      push_data[i] = '{idx: rt_xrf_rvv2rvs[i].rt_index, data: rt_xrf_rvv2rvs[i].rt_data};
    end
  end

  // A grant drains as many head entries as there are ports, or fewer if the
  // buffer holds less.
  always_comb begin
    pop_cnt = '0;
    if (xrf_grant) begin
      pop_cnt = (count < CW'(XRF_WR_PORTS)) ? count : CW'(XRF_WR_PORTS);
    end
  end

  rvs_multi_fifo #(
    .N_PUSH (NUM_RT_UOP),
    .N_POP  (XRF_WR_PORTS),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_valid (rt_xrf_valid_rvv2rvs),
    .push_data  (push_data),
    .push_ready (rt_xrf_ready_rvs2rvv),
    .pop_cnt    (pop_cnt),
    .head_data  (head_data),
    .count      (count)
  );

  // Popped x0 writes are consumed silently. When a younger popped entry
  // targets the same register, the older write is dropped so the register
  // file ends up with the younger value regardless of port priority.
  always_comb begin
    xrf_wen_d   = '0;
    xrf_waddr_d = xrf_waddr_q;
    xrf_wdata_d = xrf_wdata_q;
    for (int j = 0; j < XRF_WR_PORTS; j++) begin
      if (CW'(j) < pop_cnt) begin
        xrf_waddr_d[j] = head_data[j].idx;
        xrf_wdata_d[j] = head_data[j].data;
        xrf_wen_d[j]   = (head_data[j].idx != 5'd0);
        for (int k = j + 1; k < XRF_WR_PORTS; k++) begin
          if ((CW'(k) < pop_cnt) && (head_data[k].idx == head_data[j].idx)) begin
            xrf_wen_d[j] = 1'b0;
          end
        end
      end
    end
  end

  // Set is ORed after the clear so a simultaneous saturation wins.
  always_comb begin
    vxsat_set = 1'b0;
    for (int i = 0; i < NUM_RT_UOP; i++) begin
      vxsat_set = vxsat_set | (wr_vxsat_valid[i] & wr_vxsat[i][0]);
    end
    vxsat_d = (vxsat_clr ? 1'b0 : vxsat_q) | vxsat_set;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      xrf_wen_q   <= '0;
      xrf_waddr_q <= '0;
      xrf_wdata_q <= '0;
      vxsat_q     <= 1'b0;
    end else begin
      xrf_wen_q   <= xrf_wen_d;
      xrf_waddr_q <= xrf_waddr_d;
      xrf_wdata_q <= xrf_wdata_d;
      vxsat_q     <= vxsat_d;
    end
  end

  assign xrf_wen        = xrf_wen_q;
  assign xrf_waddr      = xrf_waddr_q;
  assign xrf_wdata      = xrf_wdata_q;
  assign wr_vxsat_ready = rst_n;
  assign pending_cnt    = count;
  assign rt_empty       = (count == '0);

endmodule
